// File: rtl/mac_beam_sched.sv
// mac_beam_sched: replays each accepted RE once per beam into mac_ants with that beam's codeword, double-banked codewords, and a tag stream aligned to the MAC latency
module mac_beam_sched #(
    parameter int ANT     = 32,
    parameter int IW      = 32,
    parameter int NBEAM   = 16,
    parameter int NRE     = 480,
    parameter int MAC_LAT = 4
) (
    input  logic                       i_clk,
    input  logic                       reset,
    input  logic [ANT*IW-1:0]          i_ants_data,
    input  logic                       i_valid,
    input  logic                       i_sop,
    output logic                       o_ready,
    input  logic                       i_cw_wr,
    input  logic [$clog2(NBEAM)-1:0]   i_cw_addr,
    input  logic [ANT*IW-1:0]          i_cw_data,
    input  logic                       i_cw_swap,
    output logic [ANT*IW-1:0]          o_mac_ants_data,
    output logic [ANT*IW-1:0]          o_mac_code_word,
    output logic                       o_mac_rvalid,
    output logic                       o_tag_valid,
    output logic [$clog2(NBEAM)-1:0]   o_tag_beam,
    output logic [$clog2(NRE)-1:0]     o_tag_re,
    output logic                       o_tag_sop,
    output logic                       o_tag_eop,
    output logic                       o_busy,
    output logic                       o_re_overflow
);
    localparam int W  = ANT * IW;
    localparam int BW = $clog2(NBEAM);
    localparam int RW = $clog2(NRE);
    localparam int TW = BW + RW + 3;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]    state;
    logic [BW-1:0] beam_cnt;
    logic [RW-1:0] re_cnt;
    logic          active;
    logic          swap_pending;
    logic [W-1:0]  bank [2][NBEAM];
    logic [TW-1:0] tag_q [MAC_LAT];
    logic          last;
    logic          acc;
    logic          pend;
    logic          swap_now;
    logic          sel;
    logic          re_last;
    logic [BW-1:0] beam_nxt;
    logic [TW-1:0] tag_in;

    // Handshake, bank selection (a swap takes effect on the cycle it is applied) and next beam/tag values
    always_comb begin
        last     = beam_cnt == BW'(NBEAM - 1);
        re_last  = re_cnt == RW'(NRE - 1);
        o_ready  = !reset && (state == IDLE || last);
        acc      = i_valid && o_ready;
        pend     = swap_pending || i_cw_swap;
        swap_now = pend && (state == IDLE || (acc && i_sop));
        sel      = active ^ swap_now;
        beam_nxt = acc ? '0 : beam_cnt + 1'b1;
        o_busy   = state == RUN;
        tag_in   = {o_mac_rvalid, beam_cnt, re_cnt,
                    o_mac_rvalid && beam_cnt == '0 && re_cnt == '0,
                    o_mac_rvalid && last && re_last};
    end

    // Scheduler FSM, RE/beam counters, swap control and registered MAC drive
    always_ff @(posedge i_clk) begin
        if (reset) begin
            state           <= IDLE;
            beam_cnt        <= '0;
            re_cnt          <= '0;
            active          <= 1'b0;
            swap_pending    <= 1'b0;
            o_re_overflow   <= 1'b0;
            o_mac_rvalid    <= 1'b0;
            o_mac_ants_data <= '0;
            o_mac_code_word <= '0;
        end else begin
            active       <= sel;
            swap_pending <= pend && !swap_now;
            o_mac_rvalid <= acc || (state == RUN && !last);
            if (acc) begin
                state           <= RUN;
                o_mac_ants_data <= i_ants_data;
                re_cnt          <= (i_sop || re_last) ? '0 : re_cnt + 1'b1;
                if (!i_sop && re_last) o_re_overflow <= 1'b1;
            end else if (state == RUN && last) begin
                state <= IDLE;
            end
            if (acc || state == RUN) begin
                beam_cnt        <= beam_nxt;
                o_mac_code_word <= bank[sel][beam_nxt];
            end
        end
    end

    // Codeword writes always target the shadow bank; contents are not reset
    always_ff @(posedge i_clk) begin
        if (i_cw_wr) bank[~active][i_cw_addr] <= i_cw_data;
    end

    // Tag delay line matching the mac_ants latency
    always_ff @(posedge i_clk) begin
        if (reset) begin
            for (int i = 0; i < MAC_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < MAC_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign {o_tag_valid, o_tag_beam, o_tag_re, o_tag_sop, o_tag_eop} = tag_q[MAC_LAT-1];
endmodule

// File: tb/tb_mac_beam_sched.sv
// tb_mac_beam_sched: randomized and directed checks of mac_beam_sched against a transaction-level queue model
module tb_mac_beam_sched;
    localparam int ANT = 32, IW = 32, NBEAM = 16, NRE = 480, MAC_LAT = 4;
    localparam int W = ANT * IW;

    logic          i_clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  i_ants_data = '0;
    logic          i_valid = 1'b0, i_sop = 1'b0, i_cw_wr = 1'b0, i_cw_swap = 1'b0;
    logic [3:0]    i_cw_addr = '0;
    logic [W-1:0]  i_cw_data = '0;
    logic          o_ready, o_mac_rvalid, o_tag_valid, o_tag_sop, o_tag_eop, o_busy, o_re_overflow;
    logic [W-1:0]  o_mac_ants_data, o_mac_code_word;
    logic [3:0]    o_tag_beam;
    logic [8:0]    o_tag_re;

    always #5 i_clk = ~i_clk;

    mac_beam_sched #(.ANT(ANT), .IW(IW), .NBEAM(NBEAM), .NRE(NRE), .MAC_LAT(MAC_LAT)) dut (
        .i_clk(i_clk), .reset(reset), .i_ants_data(i_ants_data), .i_valid(i_valid), .i_sop(i_sop),
        .o_ready(o_ready), .i_cw_wr(i_cw_wr), .i_cw_addr(i_cw_addr), .i_cw_data(i_cw_data),
        .i_cw_swap(i_cw_swap), .o_mac_ants_data(o_mac_ants_data), .o_mac_code_word(o_mac_code_word),
        .o_mac_rvalid(o_mac_rvalid), .o_tag_valid(o_tag_valid), .o_tag_beam(o_tag_beam),
        .o_tag_re(o_tag_re), .o_tag_sop(o_tag_sop), .o_tag_eop(o_tag_eop), .o_busy(o_busy),
        .o_re_overflow(o_re_overflow)
    );

    typedef struct {logic [W-1:0] d; int bank; int beam; int re;} ent_t;
    typedef struct {bit v; int beam; int re; bit sop; bit eop;} tag_t;

    ent_t         q[$];
    ent_t         cur;
    bit           cur_v, cur_k;
    logic [W-1:0] cur_cw;
    tag_t         th[$];
    logic [W-1:0] mbank [2][NBEAM];
    bit           known [2][NBEAM];
    int           act, re_m, n_acc, checks, errors, eop_seen, start;
    bit           pend, ovf, armed, done;

    function automatic logic [W-1:0] fill(input int r, input int im);
        logic [W-1:0] v;
        for (int k = 0; k < ANT; k++) v[IW*k +: IW] = {r[15:0], im[15:0]};
        return v;
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] v;
        for (int k = 0; k < ANT; k++) v[IW*k +: IW] = $urandom;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (low 128 bits)", tag, obs[127:0], exp[127:0]);
        end
    endtask

    task automatic clear_tags();
        th.delete();
        repeat (MAC_LAT) th.push_back('{default: 0});
    endtask

    // One clock: drive inputs, compare outputs with the model, then advance the model across the edge
    task automatic cyc(input bit v, input bit s, input bit wr, input int addr, input logic [W-1:0] wd,
                       input bit sw, input logic [W-1:0] ants, input bit rst);
        tag_t t;
        bit   acc, p, apply;
        int   na;
        reset = rst; i_valid = v; i_sop = s; i_cw_wr = wr; i_cw_addr = addr[3:0];
        i_cw_data = wd; i_cw_swap = sw; i_ants_data = ants;
        #1;
        if (armed) begin
            chk("ready", W'(o_ready), W'(!rst && q.size() == 0));
            chk("rvalid", W'(o_mac_rvalid), W'(cur_v));
            chk("busy", W'(o_busy), W'(cur_v));
            chk("overflow", W'(o_re_overflow), W'(ovf));
            if (cur_v) begin
                chk("ants_data", o_mac_ants_data, cur.d);
                if (cur_k) chk("code_word", o_mac_code_word, cur_cw);
            end
            t = th[0];
            chk("tag_valid", W'(o_tag_valid), W'(t.v));
            if (t.v) begin
                chk("tag_beam", W'(o_tag_beam), W'(t.beam));
                chk("tag_re", W'(o_tag_re), W'(t.re));
                chk("tag_sop", W'(o_tag_sop), W'(t.sop));
                chk("tag_eop", W'(o_tag_eop), W'(t.eop));
            end
            if (o_tag_valid === 1'b1 && o_tag_eop === 1'b1) eop_seen++;
        end
        void'(th.pop_front());
        th.push_back('{cur_v, cur.beam, cur.re, cur_v && cur.beam == 0 && cur.re == 0,
                       cur_v && cur.beam == NBEAM - 1 && cur.re == NRE - 1});
        if (rst) begin
            q.delete(); cur_v = 0; act = 0; pend = 0; re_m = 0; ovf = 0;
            clear_tags();
            for (int b = 0; b < NBEAM; b++) begin known[0][b] = 0; known[1][b] = 0; end
        end else begin
            acc   = v && q.size() == 0;
            p     = pend || sw;
            apply = p && (!cur_v || (acc && s));
            na    = apply ? 1 - act : act;
            if (acc) begin
                n_acc++;
                if (s) re_m = 0;
                else if (re_m == NRE - 1) begin re_m = 0; ovf = 1; end
                else re_m++;
                for (int b = 0; b < NBEAM; b++) q.push_back('{ants, na, b, re_m});
            end
            if (q.size() > 0) begin
                cur = q.pop_front(); cur_v = 1;
                cur_cw = mbank[cur.bank][cur.beam]; cur_k = known[cur.bank][cur.beam];
            end else cur_v = 0;
            if (wr) begin mbank[1-act][addr] = wd; known[1-act][addr] = 1; end
            act  = na;
            pend = p && !apply;
        end
        armed = 1;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, '0, 0, '0, 0);
    endtask

    task automatic send(input bit s, input logic [W-1:0] ants);
        int target = n_acc + 1;
        for (int c = 0; c < 40 && n_acc < target; c++) cyc(1, s, 0, 0, '0, 0, ants, 0);
    endtask

    initial begin
        clear_tags();
        @(negedge i_clk);
        repeat (3) cyc(0, 0, 0, 0, '0, 0, '0, 1);
        // Basic: beam b codeword {b+1,0}, swap in IDLE, one sop RE of {1,0}
        for (int b = 0; b < NBEAM; b++) cyc(0, 0, 1, b, fill(b + 1, 0), 0, '0, 0);
        cyc(0, 0, 0, 0, '0, 1, '0, 0);
        send(1, fill(1, 0));
        idle(24);
        // Full symbol with i_valid held high; mid-RE 10 rewrite beam 3 and request a swap
        start = n_acc; done = 0;
        for (int c = 0; c < 8000 && n_acc < start + NRE; c++) begin
            bit mid = !done && n_acc == start + 11 && q.size() == 8;
            cyc(1, n_acc == start, mid, 3, fill(7, 0), mid, rnd(), 0);
            if (mid) done = 1;
        end
        chk("symbol_res", W'(n_acc - start), W'(NRE));
        // 481st RE without sop wraps the RE index and sets overflow
        send(0, rnd());
        idle(24);
        chk("eop_once", W'(eop_seen), W'(1));
        chk("overflow_sticky", W'(o_re_overflow), W'(1));
        // Next sop RE sees the swapped bank (beam 3 = {7,0})
        send(1, rnd());
        idle(24);
        // Reset while beam 8 of an RE is on the MAC drive
        send(1, rnd());
        for (int c = 0; c < 20 && !(cur_v && cur.beam == 8); c++) idle(1);
        cyc(0, 0, 0, 0, '0, 0, '0, 1);
        idle(20);
        // Same-cycle codeword write and swap in IDLE
        for (int b = 0; b < NBEAM - 1; b++) cyc(0, 0, 1, b, rnd(), 0, '0, 0);
        cyc(0, 0, 1, NBEAM - 1, rnd(), 1, '0, 0);
        send(1, rnd());
        idle(24);
        // Random traffic, writes and swaps
        for (int c = 0; c < 600; c++)
            cyc($urandom_range(3) != 0, $urandom_range(7) == 0, $urandom_range(3) == 0,
                $urandom_range(NBEAM - 1), rnd(), $urandom_range(15) == 0, rnd(), 0);
        idle(24);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
